// File: rtl/accum_ctrl_pkg.sv
// Shared types and defaults for the accum lane sequencer.
package accum_ctrl_pkg;

    localparam int CWIDTH_DEF = 8;
    localparam int PWIDTH_DEF = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CLEAR = 3'd2,
        ACCUM = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } accum_ctrl_state_t;

endpackage

// File: rtl/accum_ctrl_counter.sv
// Up-counter with sync clear/enable and a "last before limit" flag.
module ctrl_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] cnt,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    // Extra bit keeps cnt+1 from wrapping onto a limit of 0.
    assign last = (({1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1}) == {1'b0, limit});

endmodule

// File: rtl/accum_ctrl.sv
// Per-pixel clear / gate-terms / emit sequencer for one accum lane.
module accum_ctrl
    import accum_ctrl_pkg::*;
#(
    parameter int CWIDTH = CWIDTH_DEF,
    parameter int PWIDTH = PWIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CWIDTH-1:0] n_in,
    input  logic [PWIDTH-1:0] n_pix,
    input  logic              term_valid,
    output logic              term_ready,
    output logic              acc_reset,
    output logic              acc_en,
    output logic              acc_out_en,
    output logic              out_valid,
    output logic [PWIDTH-1:0] pix_idx,
    output logic              busy,
    output logic              done
);

    accum_ctrl_state_t state, next_state;
    logic [CWIDTH-1:0] n_in_q;
    logic [PWIDTH-1:0] n_pix_q;
    logic [CWIDTH-1:0] chan_cnt;
    logic [PWIDTH-1:0] pix_cnt;
    logic              chan_last, pix_last, accept;
    logic              unused_chan;

    assign accept      = term_valid && term_ready;
    assign acc_en      = accept;
    assign pix_idx     = pix_cnt;
    assign unused_chan = ^chan_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            n_in_q    <= '0;
            n_pix_q   <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            out_valid <= (state == EMIT);
            // Counts are captured on the start cycle so later port changes cannot leak in.
            if (state == IDLE && start) begin
                n_in_q  <= n_in;
                n_pix_q <= n_pix;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = (n_in_q == '0 || n_pix_q == '0) ? DONE : CLEAR;
            CLEAR:   next_state = ACCUM;
            ACCUM:   if (accept && chan_last) next_state = EMIT;
            EMIT:    next_state = pix_last ? DONE : CLEAR;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        term_ready = (state == ACCUM);
        acc_reset  = (state == CLEAR);
        acc_out_en = (state == EMIT);
        busy       = (state != IDLE);
        done       = (state == DONE);
    end

    ctrl_counter #(.WIDTH(CWIDTH)) u_chan_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state == CLEAR),
        .en    (accept),
        .limit (n_in_q),
        .cnt   (chan_cnt),
        .last  (chan_last)
    );

    ctrl_counter #(.WIDTH(PWIDTH)) u_pix_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state == LOAD),
        .en    (state == EMIT),
        .limit (n_pix_q),
        .cnt   (pix_cnt),
        .last  (pix_last)
    );

endmodule
